// File: rtl/gradient_engine_if.sv
// Handshake bundle for gradient_engine: frame control, frame-buffer read port
// and result write port.
interface gradient_engine_if #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned COORD_W = 10
);
    logic               start;
    logic [1:0]         mode;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [WORD_W-1:0]  rd_data;
    logic               wr_en;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WORD_W-1:0]  wr_data;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;

    modport master (
        input  start, mode, rd_data, wr_ready,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, cur_x, cur_y
    );
    modport slave (
        output start, mode, rd_data, wr_ready,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, cur_x, cur_y
    );
endinterface

// File: rtl/gradient_engine.sv
// Streams a packed-pixel frame from a frame-buffer RAM and writes one packed
// absolute-gradient word (|gx|, |gy|, saturated sum or max) per input word.
module gradient_engine #(
    parameter int unsigned IMG_W        = 320,
    parameter int unsigned IMG_H        = 240,
    parameter int unsigned PIX_BITS     = 4,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned COORD_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    gradient_engine_if.master  bus
);
    localparam int unsigned WORD_W = PIX_BITS * PIX_PER_WORD;
    localparam int unsigned WPR    = IMG_W / PIX_PER_WORD;
    localparam int unsigned COL_W  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [PIX_BITS-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_CALC, S_WR, S_FIN} state_e;

    state_e              state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [1:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic [COORD_W-1:0]  cur_x_q, cur_x_d;
    logic [COORD_W-1:0]  cur_y_q, cur_y_d;
    logic [WORD_W-1:0]   ctr_q, ctr_d, lft_q, lft_d, rgt_q, rgt_d, up_q, up_d, dn_q, dn_d;
    logic                last_col, last_word;

    assign last_col  = (col_q == COL_W'(WPR - 1));
    assign last_word = last_col && (row_q == ROW_W'(IMG_H - 1));

    // Neighbour index: 0 centre, 1 left, 2 right, 3 up, 4 down (edge-clamped).
    function automatic logic [ADDR_W-1:0] issue_addr(input logic [2:0] idx,
                                                     input logic [ROW_W-1:0] r,
                                                     input logic [COL_W-1:0] c);
        logic [ROW_W-1:0] rr;
        logic [COL_W-1:0] cc;
        rr = r;
        cc = c;
        case (idx)
            3'd1:    cc = (c == '0) ? c : c - COL_W'(1);
            3'd2:    cc = (c == COL_W'(WPR - 1)) ? c : c + COL_W'(1);
            3'd3:    rr = (r == '0) ? r : r - ROW_W'(1);
            3'd4:    rr = (r == ROW_W'(IMG_H - 1)) ? r : r + ROW_W'(1);
            default: ;
        endcase
        return ADDR_W'(rr) * ADDR_W'(WPR) + ADDR_W'(cc);
    endfunction

    function automatic logic [WORD_W-1:0] calc_word(input logic [WORD_W-1:0] c, l, r, u, d,
                                                    input logic left_edge, right_edge,
                                                    input logic [1:0] m);
        logic [WORD_W-1:0]   res;
        logic [PIX_BITS-1:0] pl, pr, pu, pd, gx, gy;
        logic [PIX_BITS:0]   sum;
        int                  km, kp;
        res = '0;
        for (int k = 0; k < int'(PIX_PER_WORD); k++) begin
            km = (k == 0) ? 0 : k - 1;
            kp = (k == int'(PIX_PER_WORD) - 1) ? k : k + 1;
            // At the image edge the missing neighbour is the pixel itself.
            if (k == 0) pl = left_edge ? c[PIX_BITS-1:0] : l[WORD_W-1 -: PIX_BITS];
            else        pl = c[km*PIX_BITS +: PIX_BITS];
            if (k == int'(PIX_PER_WORD) - 1) pr = right_edge ? c[WORD_W-1 -: PIX_BITS] : r[PIX_BITS-1:0];
            else                             pr = c[kp*PIX_BITS +: PIX_BITS];
            pu  = u[k*PIX_BITS +: PIX_BITS];
            pd  = d[k*PIX_BITS +: PIX_BITS];
            gx  = (pr > pl) ? pr - pl : pl - pr;
            gy  = (pd > pu) ? pd - pu : pu - pd;
            sum = {1'b0, gx} + {1'b0, gy};
            case (m)
                2'd0:    res[k*PIX_BITS +: PIX_BITS] = gx;
                2'd1:    res[k*PIX_BITS +: PIX_BITS] = gy;
                2'd2:    res[k*PIX_BITS +: PIX_BITS] = sum[PIX_BITS] ? PIX_MAX : sum[PIX_BITS-1:0];
                default: res[k*PIX_BITS +: PIX_BITS] = (gx > gy) ? gx : gy;
            endcase
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        ctr_d     = ctr_q;
        lft_d     = lft_q;
        rgt_d     = rgt_q;
        up_d      = up_q;
        dn_d      = dn_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                mode_d    = bus.mode;
                col_d     = '0;
                row_d     = '0;
                busy_d    = 1'b1;
                rd_en_d   = 1'b1;
                rd_addr_d = issue_addr(3'd0, '0, '0);
                phase_d   = '0;
                state_d   = S_RD;
            end
            // Each read cycle captures the word requested by the previous one.
            S_RD: begin
                case (phase_q)
                    3'd1:    ctr_d = bus.rd_data;
                    3'd2:    lft_d = bus.rd_data;
                    3'd3:    rgt_d = bus.rd_data;
                    3'd4:    up_d  = bus.rd_data;
                    default: ;
                endcase
                if (phase_q == 3'd4) begin
                    state_d = S_CAP;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = issue_addr(phase_q + 3'd1, row_q, col_q);
                    phase_d   = phase_q + 3'd1;
                end
            end
            S_CAP: begin
                dn_d    = bus.rd_data;
                state_d = S_CALC;
            end
            S_CALC: begin
                wr_en_d   = 1'b1;
                wr_addr_d = issue_addr(3'd0, row_q, col_q);
                wr_data_d = calc_word(ctr_q, lft_q, rgt_q, up_q, dn_q,
                                      col_q == '0, last_col, mode_q);
                cur_x_d   = COORD_W'(col_q) * COORD_W'(PIX_PER_WORD);
                cur_y_d   = COORD_W'(row_q);
                state_d   = S_WR;
            end
            S_WR: if (bus.wr_ready) begin
                wr_en_d = 1'b0;
                if (last_word) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    rd_en_d   = 1'b1;
                    rd_addr_d = issue_addr(3'd0, row_d, col_d);
                    phase_d   = '0;
                    state_d   = S_RD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            ctr_q     <= '0;
            lft_q     <= '0;
            rgt_q     <= '0;
            up_q      <= '0;
            dn_q      <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            col_q     <= col_d;
            row_q     <= row_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            ctr_q     <= ctr_d;
            lft_q     <= lft_d;
            rgt_q     <= rgt_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.cur_x   = cur_x_q;
    assign bus.cur_y   = cur_y_q;
endmodule
